// File: rtl/temp_color_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : temp_color_sequencer
// Purpose  : Periodically fetches a 4-bit temperature code from a sensor over
//            a req/ack handshake. The code is debounced by requiring several
//            identical readings, then committed to the colour decoder input
//            only on frame boundaries, so the colour never changes mid-frame.
// Ports    : clk          - system clock
//            reset        - synchronous, active-high reset
//            vsync        - one-clk pulse at frame start
//            smp_ack      - sensor: smp_data valid this cycle
//            smp_data     - sensor temperature code (4 bits)
//            smp_req      - sample request level, held until ack or timeout
//            code_out     - code driven into the colour decoder
//            code_valid   - high once the first filtered code is committed
//            update_pulse - one-clk pulse when code_out changes by commit
//            timeout_err  - sticky ack-timeout flag, cleared only by reset
// Options  : TEMP_ALARM_BLINK_EN - when defined, a committed red code (1111)
//            blinks between 1111 and 1110 every BLINK_FRAMES vsyncs.
// Revision : 1.0 - initial release
// ============================================================================
module temp_color_sequencer #(
  parameter int SAMPLE_PERIOD = 16,   // vsyncs between sample requests
  parameter int STABLE_CNT    = 3,    // identical samples needed to accept
  parameter int ACK_TIMEOUT   = 255,  // clk cycles to wait for smp_ack
  parameter int BLINK_FRAMES  = 8     // vsyncs per blink half-period
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic       smp_ack,
  input  logic [3:0] smp_data,
  output logic       smp_req,
  output logic [3:0] code_out,
  output logic       code_valid,
  output logic       update_pulse,
  output logic       timeout_err
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int c_FW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int c_MW = $clog2(STABLE_CNT + 1);
  localparam int c_TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  localparam logic [c_FW-1:0] c_FRAME_LAST = c_FW'(SAMPLE_PERIOD - 1);
  localparam logic [c_MW-1:0] c_MATCH_MAX  = c_MW'(STABLE_CNT);
  localparam logic [c_MW-1:0] c_MATCH_ONE  = c_MW'(1);
  localparam logic [c_TW-1:0] c_TO_LAST    = c_TW'(ACK_TIMEOUT - 1);

  localparam logic [3:0] c_CODE_DEFAULT = 4'b1010;  // decoder default colour
  localparam logic [3:0] c_CODE_RED     = 4'b1111;
  localparam logic [3:0] c_CODE_RED_DIM = 4'b1110;

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_REQ  = 2'd1;
  localparam logic [1:0] c_ST_CAPT = 2'd2;

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  logic [c_FW-1:0] r_frame_cnt;
  logic            w_trigger;

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic            w_smp_req_nxt;
  logic            w_ack_seen;
  logic            w_to_expired;
  logic            w_capt;

  logic            r_smp_req;
  logic [c_TW-1:0] r_to_cnt;
  logic            r_timeout_err;
  logic [3:0]      r_latched;

  logic [3:0]      w_clamped;
  logic [c_MW-1:0] w_match_nxt;
  logic            w_set_pending;
  logic            w_commit;

  logic [3:0]      r_cand;
  logic [c_MW-1:0] r_match;
  logic [3:0]      r_pending;
  logic            r_pending_new;
  logic [3:0]      r_committed;
  logic            r_code_valid;
  logic            r_update_pulse;

  // --------------------------------------------------------------------------
  // Frame counter: counts vsyncs 0..SAMPLE_PERIOD-1. The trigger fires on the
  // wrapping vsync; the counter wraps regardless of whether the FSM can
  // accept the trigger.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame_cnt <= '0;
    end else if (vsync) begin
      if (r_frame_cnt == c_FRAME_LAST) begin
        r_frame_cnt <= '0;
      end else begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
    end
  end

  assign w_trigger = vsync && (r_frame_cnt == c_FRAME_LAST);

  // --------------------------------------------------------------------------
  // Sampling FSM - state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Ack is only honoured while the request is actually visible to the sensor,
  // so an ack held high from a previous request cannot double-capture.
  assign w_ack_seen   = (r_state == c_ST_REQ) && r_smp_req && smp_ack;
  assign w_to_expired = (r_state == c_ST_REQ) && !w_ack_seen &&
                        (r_to_cnt == c_TO_LAST);

  // --------------------------------------------------------------------------
  // Sampling FSM - next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (w_trigger) begin
          w_state_nxt = c_ST_REQ;
        end
      end
      c_ST_REQ: begin
        if (w_ack_seen) begin
          w_state_nxt = c_ST_CAPT;
        end else if (w_to_expired) begin
          w_state_nxt = c_ST_IDLE;
        end
      end
      c_ST_CAPT: begin
        w_state_nxt = c_ST_IDLE;
      end
      default: begin
        w_state_nxt = c_ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Sampling FSM - output logic. smp_req is registered from the next state so
  // it is high for exactly the cycles spent in REQ.
  // --------------------------------------------------------------------------
  always_comb begin
    w_smp_req_nxt = (w_state_nxt == c_ST_REQ);
    w_capt        = (r_state == c_ST_CAPT);
  end

  // Handshake datapath: request register, timeout counter, sample latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_smp_req     <= 1'b0;
      r_to_cnt      <= '0;
      r_timeout_err <= 1'b0;
      r_latched     <= c_CODE_DEFAULT;
    end else begin
      r_smp_req <= w_smp_req_nxt;
      // Counter value k during the k-th REQ cycle; restarts on every entry.
      if ((r_state == c_ST_REQ) && (w_state_nxt == c_ST_REQ)) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end else begin
        r_to_cnt <= '0;
      end
      if (w_ack_seen) begin
        r_latched <= smp_data;
      end
      if (w_to_expired) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stability filter. Codes below the default colour are meaningless to the
  // decoder and are treated as the default.
  // --------------------------------------------------------------------------
  always_comb begin
    w_clamped = (r_latched < c_CODE_DEFAULT) ? c_CODE_DEFAULT : r_latched;
    if (w_clamped == r_cand) begin
      w_match_nxt = (r_match == c_MATCH_MAX) ? r_match : r_match + 1'b1;
    end else begin
      w_match_nxt = c_MATCH_ONE;
    end
    // Compare against the committed code, not the (possibly blinking) output.
    w_set_pending = w_capt && (w_match_nxt == c_MATCH_MAX) &&
                    (w_clamped != r_committed);
  end

  assign w_commit = vsync && r_pending_new;

  // Filter state and frame-aligned commit. A pending value set in the same
  // cycle as a vsync waits for the following vsync, because the commit looks
  // at the registered pending_new flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cand         <= c_CODE_DEFAULT;
      r_match        <= '0;
      r_pending      <= c_CODE_DEFAULT;
      r_pending_new  <= 1'b0;
      r_committed    <= c_CODE_DEFAULT;
      r_code_valid   <= 1'b0;
      r_update_pulse <= 1'b0;
    end else begin
      if (w_capt) begin
        r_cand  <= w_clamped;
        r_match <= w_match_nxt;
      end
      r_update_pulse <= w_commit && (r_pending != r_committed);
      if (w_commit) begin
        r_committed   <= r_pending;
        r_code_valid  <= 1'b1;
        r_pending_new <= 1'b0;
      end
      // A fresh acceptance overrides the clear from a simultaneous commit.
      if (w_set_pending) begin
        r_pending     <= w_clamped;
        r_pending_new <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output stage
  // --------------------------------------------------------------------------
`ifdef TEMP_ALARM_BLINK_EN
  localparam int c_BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [c_BW-1:0] c_BLINK_LAST = c_BW'(BLINK_FRAMES - 1);

  logic [c_BW-1:0] r_blink_cnt;
  logic            r_blink_dim;

  // Blink phase restarts bright on every commit and stays cleared for any
  // non-red committed code.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_blink_cnt <= '0;
      r_blink_dim <= 1'b0;
    end else if (w_commit || (r_committed != c_CODE_RED)) begin
      r_blink_cnt <= '0;
      r_blink_dim <= 1'b0;
    end else if (vsync) begin
      if (r_blink_cnt == c_BLINK_LAST) begin
        r_blink_cnt <= '0;
        r_blink_dim <= ~r_blink_dim;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

  assign code_out = r_blink_dim ? c_CODE_RED_DIM : r_committed;
`else
  logic w_unused_blink;
  assign w_unused_blink = (BLINK_FRAMES > 0);
  assign code_out       = r_committed;
`endif

  assign smp_req      = r_smp_req;
  assign code_valid   = r_code_valid;
  assign update_pulse = r_update_pulse;
  assign timeout_err  = r_timeout_err;

endmodule

`default_nettype wire

// File: tb/tb_temp_color_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_temp_color_sequencer
// Purpose  : Self-checking bench for temp_color_sequencer. A sensor model
//            answers requests from a queue of codes; expected commits are
//            queued by each scenario and checked whenever update_pulse fires.
// Options  : TEMP_ALARM_BLINK_EN - also runs the red alarm blink scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_temp_color_sequencer;

  localparam int SAMPLE_PERIOD = 2;
  localparam int STABLE_CNT    = 3;
  localparam int ACK_TIMEOUT   = 20;
  localparam int BLINK_FRAMES  = 2;
  localparam int FRAME_LEN     = 8;   // clk cycles per frame
  localparam int ACK_DLY       = 2;   // sensor answers 2 cycles after req

  logic       clk;
  logic       reset;
  logic       vsync;
  logic       smp_ack;
  logic [3:0] smp_data;
  logic       smp_req;
  logic [3:0] code_out;
  logic       code_valid;
  logic       update_pulse;
  logic       timeout_err;

  logic       mdl_ack;
  logic [3:0] mdl_data;
  logic       man_ack;
  logic [3:0] man_data;

  assign smp_ack  = mdl_ack | man_ack;
  assign smp_data = man_ack ? man_data : mdl_data;

  logic [3:0] sens_q[$];   // codes the sensor model will return
  logic [3:0] exp_q[$];    // scoreboard of expected committed codes

  int tests_run;
  int fails;

  temp_color_sequencer #(
    .SAMPLE_PERIOD(SAMPLE_PERIOD),
    .STABLE_CNT   (STABLE_CNT),
    .ACK_TIMEOUT  (ACK_TIMEOUT),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .vsync       (vsync),
    .smp_ack     (smp_ack),
    .smp_data    (smp_data),
    .smp_req     (smp_req),
    .code_out    (code_out),
    .code_valid  (code_valid),
    .update_pulse(update_pulse),
    .timeout_err (timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Sensor model: answers a visible request after ACK_DLY cycles with the
  // next queued code; an empty queue means the sensor never answers.
  initial begin
    mdl_ack  = 1'b0;
    mdl_data = 4'b0000;
    forever begin
      @(negedge clk);
      if (!reset && smp_req === 1'b1 && sens_q.size() > 0) begin
        repeat (ACK_DLY) @(negedge clk);
        if (!reset && smp_req === 1'b1 && sens_q.size() > 0) begin
          mdl_ack  = 1'b1;
          mdl_data = sens_q.pop_front();
          @(negedge clk);
          mdl_ack  = 1'b0;
        end
      end
    end
  end

  // Scoreboard monitor: every update_pulse must match the next expected code.
  logic       prev_pulse;
  logic [3:0] prev_code;
  initial begin
    logic [3:0] e;
    prev_pulse = 1'b0;
    prev_code  = 4'b1010;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_pulse = 1'b0;
        prev_code  = code_out;
      end else begin
        if (update_pulse === 1'b1) begin
          tests_run++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_update: code_out=%b, no commit expected", code_out);
          end else begin
            e = exp_q.pop_front();
            if (code_out !== e) begin
              fails++;
              $display("FAIL commit_value: code_out=%b expected %b", code_out, e);
            end
          end
          tests_run++;
          if (prev_pulse) begin
            fails++;
            $display("FAIL pulse_width: update_pulse high 2+ cycles, expected 1");
          end
        end
`ifndef TEMP_ALARM_BLINK_EN
        if (code_out !== prev_code) begin
          tests_run++;
          if (update_pulse !== 1'b1) begin
            fails++;
            $display("FAIL silent_change: code_out %b->%b update_pulse=%b expected 1",
                     prev_code, code_out, update_pulse);
          end
        end
`endif
        prev_pulse = update_pulse;
        prev_code  = code_out;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic do_reset();
    reset   = 1'b1;
    vsync   = 1'b0;
    man_ack = 1'b0;
    sens_q.delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // One-cycle vsync; returns on the negedge just after the vsync edge.
  task automatic pulse_vsync();
    vsync = 1'b1;
    @(negedge clk);
    vsync = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      pulse_vsync();
      repeat (FRAME_LEN - 1) @(negedge clk);
    end
  endtask

  task automatic check_sb_empty(input string name);
    tests_run++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_sb_empty: %0d expected commits never seen, expected 0", name, exp_q.size());
    end
  endtask

  // --------------------------------------------------------------------------
  // Scenarios
  // --------------------------------------------------------------------------
  task automatic test_reset();
    do_reset();
    frames(1);
    tests_run++;
    if (code_out !== 4'b1010) begin
      fails++; $display("FAIL reset_code: code_out=%b expected 1010", code_out);
    end
    tests_run++;
    if (code_valid !== 1'b0) begin
      fails++; $display("FAIL reset_valid: code_valid=%b expected 0", code_valid);
    end
    tests_run++;
    if (smp_req !== 1'b0) begin
      fails++; $display("FAIL reset_req: smp_req=%b expected 0", smp_req);
    end
    tests_run++;
    if (timeout_err !== 1'b0 || update_pulse !== 1'b0) begin
      fails++; $display("FAIL reset_flags: timeout_err=%b update_pulse=%b expected 0/0",
                        timeout_err, update_pulse);
    end
  endtask

  task automatic test_basic_commit();
    do_reset();
    for (int i = 0; i < 3; i++) sens_q.push_back(4'b1100);
    exp_q.push_back(4'b1100);
    frames(6);   // samples on vsync 2,4,6
    tests_run++;
    if (code_out !== 4'b1010 || code_valid !== 1'b0) begin
      fails++; $display("FAIL basic_early: code_out=%b valid=%b expected 1010/0", code_out, code_valid);
    end
    pulse_vsync();  // vsync 7 commits
    tests_run++;
    if (code_out !== 4'b1100 || code_valid !== 1'b1 || update_pulse !== 1'b1) begin
      fails++; $display("FAIL basic_commit: code_out=%b valid=%b pulse=%b expected 1100/1/1",
                        code_out, code_valid, update_pulse);
    end
    @(negedge clk);
    tests_run++;
    if (update_pulse !== 1'b0) begin
      fails++; $display("FAIL basic_pulse_end: update_pulse=%b expected 0", update_pulse);
    end
    check_sb_empty("basic");
  endtask

  task automatic test_filter();
    logic [3:0] seq [6] = '{4'b1101, 4'b1101, 4'b1110, 4'b1101, 4'b1101, 4'b1101};
    do_reset();
    foreach (seq[i]) sens_q.push_back(seq[i]);
    exp_q.push_back(4'b1101);
    frames(11);  // five samples taken
    tests_run++;
    if (code_out !== 4'b1010 || code_valid !== 1'b0) begin
      fails++; $display("FAIL filter_hold: code_out=%b valid=%b expected 1010/0", code_out, code_valid);
    end
    frames(2);   // sixth sample, then commit
    tests_run++;
    if (code_out !== 4'b1101 || code_valid !== 1'b1) begin
      fails++; $display("FAIL filter_commit: code_out=%b valid=%b expected 1101/1", code_out, code_valid);
    end
    check_sb_empty("filter");
  endtask

  task automatic test_clamp();
    do_reset();
    for (int i = 0; i < 3; i++) sens_q.push_back(4'b0011);
    frames(8);
    tests_run++;
    if (code_out !== 4'b1010 || code_valid !== 1'b0) begin
      fails++; $display("FAIL clamp: code_out=%b valid=%b expected 1010/0", code_out, code_valid);
    end
    tests_run++;
    if (sens_q.size() != 0) begin
      fails++; $display("FAIL clamp_samples: %0d samples unconsumed, expected 0", sens_q.size());
    end
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    frames(1);
    pulse_vsync();  // trigger; sensor queue empty so no ack
    n = 0;
    for (int i = 0; i < 3 * ACK_TIMEOUT; i++) begin
      if (smp_req === 1'b1) n++;
      @(negedge clk);
    end
    tests_run++;
    if (n != ACK_TIMEOUT) begin
      fails++; $display("FAIL timeout_len: smp_req high %0d cycles, expected %0d", n, ACK_TIMEOUT);
    end
    tests_run++;
    if (timeout_err !== 1'b1) begin
      fails++; $display("FAIL timeout_err: timeout_err=%b expected 1", timeout_err);
    end
    frames(1);
    pulse_vsync();  // next trigger
    tests_run++;
    if (smp_req !== 1'b1) begin
      fails++; $display("FAIL timeout_rereq: smp_req=%b expected 1", smp_req);
    end
    repeat (ACK_TIMEOUT + 10) @(negedge clk);
    tests_run++;
    if (timeout_err !== 1'b1 || smp_req !== 1'b0) begin
      fails++; $display("FAIL timeout_sticky: timeout_err=%b smp_req=%b expected 1/0", timeout_err, smp_req);
    end
  endtask

  task automatic test_reset_mid_handshake();
    do_reset();
    frames(1);
    pulse_vsync();
    tests_run++;
    if (smp_req !== 1'b1) begin
      fails++; $display("FAIL midreset_req_up: smp_req=%b expected 1", smp_req);
    end
    reset = 1'b1;
    @(negedge clk);
    tests_run++;
    if (smp_req !== 1'b0) begin
      fails++; $display("FAIL midreset_req_drop: smp_req=%b expected 0", smp_req);
    end
    reset    = 1'b0;
    man_data = 4'b1111;
    man_ack  = 1'b1;   // late ack must be ignored
    @(negedge clk);
    man_ack  = 1'b0;
    sens_q.push_back(4'b1111);
    sens_q.push_back(4'b1111);
    frames(5);   // two real samples: not enough unless the late ack counted
    tests_run++;
    if (code_valid !== 1'b0 || code_out !== 4'b1010) begin
      fails++; $display("FAIL midreset_late_ack: code_out=%b valid=%b expected 1010/0", code_out, code_valid);
    end
    sens_q.push_back(4'b1111);
    exp_q.push_back(4'b1111);
    frames(2);
    tests_run++;
    if (code_out !== 4'b1111 || code_valid !== 1'b1) begin
      fails++; $display("FAIL midreset_commit: code_out=%b valid=%b expected 1111/1", code_out, code_valid);
    end
    check_sb_empty("midreset");
  endtask

  task automatic test_back_to_back();
    do_reset();
    man_data = 4'b1011;
    man_ack  = 1'b1;   // ack held high across requests
    frames(5);         // two requests
    tests_run++;
    if (code_valid !== 1'b0) begin
      fails++; $display("FAIL held_ack_once: code_valid=%b expected 0 after 2 requests", code_valid);
    end
    exp_q.push_back(4'b1011);
    frames(2);
    tests_run++;
    if (code_out !== 4'b1011 || code_valid !== 1'b1) begin
      fails++; $display("FAIL held_ack_commit: code_out=%b valid=%b expected 1011/1", code_out, code_valid);
    end
    man_ack = 1'b0;
    check_sb_empty("held_ack");
  endtask

`ifdef TEMP_ALARM_BLINK_EN
  task automatic test_blink();
    logic [3:0] seq [4] = '{4'b1111, 4'b1110, 4'b1110, 4'b1111};
    do_reset();
    for (int i = 0; i < 3; i++) sens_q.push_back(4'b1111);
    exp_q.push_back(4'b1111);
    frames(6);
    pulse_vsync();
    tests_run++;
    if (code_out !== 4'b1111) begin
      fails++; $display("FAIL blink_commit: code_out=%b expected 1111", code_out);
    end
    for (int k = 0; k < 4; k++) begin
      repeat (FRAME_LEN - 1) @(negedge clk);
      pulse_vsync();
      tests_run++;
      if (code_out !== seq[k] || update_pulse !== 1'b0) begin
        fails++; $display("FAIL blink_seq%0d: code_out=%b pulse=%b expected %b/0",
                          k, code_out, update_pulse, seq[k]);
      end
    end
    check_sb_empty("blink");
  endtask
`endif

  initial begin
    tests_run = 0;
    fails     = 0;
    reset     = 1'b1;
    vsync     = 1'b0;
    man_ack   = 1'b0;
    man_data  = 4'b0000;
    @(negedge clk);
    test_reset();
    test_basic_commit();
    test_filter();
    test_clamp();
    test_timeout();
    test_reset_mid_handshake();
    test_back_to_back();
`ifdef TEMP_ALARM_BLINK_EN
    test_blink();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

`default_nettype wire
